// File: rtl/seq_player_pkg.sv
// Shared definitions for the button-sequence player: FSM states, step-code
// layout, button indices and the default reset sequence.
package seq_player_pkg;

  localparam int STEP_W    = 2;
  localparam int NUM_STEPS = 4;
  localparam int CODE_W    = STEP_W * NUM_STEPS;
  localparam int CNT_W     = 27;
  localparam int IDX_W     = 3;

  // Button indices shared with the sequence detector; 0 terminates a sequence.
  localparam logic [STEP_W-1:0] BTN_NONE = 2'd0;
  localparam logic [STEP_W-1:0] BTN_1    = 2'd1;
  localparam logic [STEP_W-1:0] BTN_2    = 2'd2;
  localparam logic [STEP_W-1:0] BTN_3    = 2'd3;

  // Default sequence 2,3,1,3 (step0 in the low bits).
  localparam logic [CODE_W-1:0] RST_CODE_DEF = 8'hDE;

  typedef enum logic [2:0] {
    IDLE,
    ON,
    GAP,
    ENTER,
    FIN
  } state_t;

  function automatic logic [2:0] btn_onehot(input logic [STEP_W-1:0] b);
    case (b)
      BTN_1:   return 3'b001;
      BTN_2:   return 3'b010;
      BTN_3:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [STEP_W-1:0] step_at(input logic [CODE_W-1:0] code,
                                                input logic [1:0]        idx);
    return code[{idx, 1'b0} +: STEP_W];
  endfunction

endpackage

// File: rtl/seq_player_step_timer.sv
// Loadable terminal-count counter used for the ON and GAP dwell times.
module step_timer
  import seq_player_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         restart,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (clr || restart) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  // tc marks the last cycle of a window of length term (term >= 1).
  assign tc = (count == term - W'(1));

endmodule

// File: rtl/seq_player.sv
// Plays a stored 4-step button sequence on the LEDs, pulsing each button and
// a final enter, for injecting a code into the sequence detector.
module seq_player
  import seq_player_pkg::*;
#(
  parameter int                ON_CYCLES  = 62500000,
  parameter int                GAP_CYCLES = 12500000,
  parameter logic [CODE_W-1:0] RST_CODE   = RST_CODE_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              seq_wr,
  input  logic [CODE_W-1:0] seq_wr_data,
  output logic [2:0]        led,
  output logic [2:0]        btn_pulse,
  output logic              enter_pulse,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] ON_TERM  = CNT_W'(ON_CYCLES);
  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(GAP_CYCLES);

  state_t            state;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] play;
  logic [IDX_W-1:0]  idx;

  logic              tc;
  logic              restart;
  logic [CNT_W-1:0]  term;
  logic [CODE_W-1:0] snap;
  logic [IDX_W-1:0]  nxt_idx;
  logic [STEP_W-1:0] nxt_step;
  logic [STEP_W-1:0] first_step;

  // A write in the same cycle as start must be the one that gets played.
  assign snap       = seq_wr ? seq_wr_data : code;
  assign first_step = step_at(snap, 2'd0);
  assign nxt_idx    = idx + IDX_W'(1);
  assign nxt_step   = step_at(play, nxt_idx[1:0]);

  assign term    = (state == GAP) ? GAP_TERM : ON_TERM;
  assign restart = !((state == ON) || (state == GAP)) || tc;

  step_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .clr     (clr),
    .restart (restart),
    .term    (term),
    .tc      (tc)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      idx         <= '0;
      code        <= RST_CODE;
      play        <= RST_CODE;
      led         <= '0;
      btn_pulse   <= '0;
      enter_pulse <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      btn_pulse   <= '0;
      enter_pulse <= 1'b0;
      done        <= 1'b0;
      if (seq_wr) begin
        code <= seq_wr_data;
      end
      case (state)
        IDLE: begin
          if (start) begin
            play <= snap;
            idx  <= '0;
            busy <= 1'b1;
            if (first_step != BTN_NONE) begin
              state     <= ON;
              led       <= btn_onehot(first_step);
              btn_pulse <= btn_onehot(first_step);
            end else begin
              state       <= ENTER;
              enter_pulse <= 1'b1;
            end
          end
        end
        ON: begin
          if (tc) begin
            state <= GAP;
            led   <= '0;
          end
        end
        GAP: begin
          if (tc) begin
            idx <= nxt_idx;
            // A zero step ends playback; anything after it is never shown.
            if ((idx == IDX_W'(NUM_STEPS - 1)) || (nxt_step == BTN_NONE)) begin
              state       <= ENTER;
              enter_pulse <= 1'b1;
            end else begin
              state     <= ON;
              led       <= btn_onehot(nxt_step);
              btn_pulse <= btn_onehot(nxt_step);
            end
          end
        end
        ENTER: begin
          state <= FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          led   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with ON_CYCLES=4, GAP_CYCLES=2.
module tb_seq_player;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic       seq_wr;
  logic [7:0] seq_wr_data;
  logic [2:0] led;
  logic [2:0] btn_pulse;
  logic       enter_pulse;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  seq_player #(
    .ON_CYCLES  (4),
    .GAP_CYCLES (2),
    .RST_CODE   (8'hDE)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .seq_wr      (seq_wr),
    .seq_wr_data (seq_wr_data),
    .led         (led),
    .btn_pulse   (btn_pulse),
    .enter_pulse (enter_pulse),
    .busy        (busy),
    .done        (done)
  );

  always #4 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Expected per-step LED patterns are packed as leds[3*s +: 3] for step s.
  task automatic run_seq(input string tag, input int k, input logic [11:0] leds,
                         input bit hold, input int wr_at, input logic [7:0] wr_data);
    int n;
    int s;
    int ph;
    logic [2:0] el;
    logic [2:0] eb;
    n = k * 6 + 1;
    start = 1'b1;
    step_clk();
    seq_wr = 1'b0;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      el = 3'b000;
      eb = 3'b000;
      if (c < n) begin
        s  = (c - 1) / 6;
        ph = (c - 1) % 6;
        if (ph < 4) el = leds[3*s +: 3];
        if (ph == 0) eb = el;
      end
      chk({tag, ".led"}, 32'(led), 32'(el));
      chk({tag, ".btn"}, 32'(btn_pulse), 32'(eb));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".enter"}, 32'(enter_pulse), (c == n) ? 32'd1 : 32'd0);
      chk({tag, ".done_early"}, 32'(done), 32'd0);
      if (c == wr_at) begin
        seq_wr      = 1'b1;
        seq_wr_data = wr_data;
      end
      step_clk();
      seq_wr = 1'b0;
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".fin_busy"}, 32'(busy), 32'd0);
    chk({tag, ".fin_enter"}, 32'(enter_pulse), 32'd0);
    chk({tag, ".fin_led"}, 32'(led), 32'd0);
    step_clk();
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    clr         = 1'b1;
    start       = 1'b1;
    seq_wr      = 1'b1;
    seq_wr_data = 8'h55;
    step_clk();
    step_clk();
    chk("rst.led", 32'(led), 32'd0);
    chk("rst.btn", 32'(btn_pulse), 32'd0);
    chk("rst.enter", 32'(enter_pulse), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    start  = 1'b0;
    seq_wr = 1'b0;
    clr    = 1'b0;
    step_clk();
    chk("idle.busy", 32'(busy), 32'd0);

    // Default sequence 2,3,1,3; the write issued under clr must not stick.
    run_seq("dflt", 4, {3'b100, 3'b001, 3'b100, 3'b010}, 1'b0, 0, 8'h00);

    seq_wr = 1'b1;
    seq_wr_data = 8'h01;
    step_clk();
    seq_wr = 1'b0;
    run_seq("one", 1, {9'b0, 3'b001}, 1'b0, 0, 8'h00);

    // Write and start in the same cycle: the new empty code is played.
    seq_wr = 1'b1;
    seq_wr_data = 8'h00;
    run_seq("empty", 0, 12'b0, 1'b0, 0, 8'h00);

    // Step1 is zero, so the nonzero step2 must be ignored.
    seq_wr = 1'b1;
    seq_wr_data = 8'h31;
    step_clk();
    seq_wr = 1'b0;
    run_seq("term0", 1, {9'b0, 3'b001}, 1'b0, 0, 8'h00);

    seq_wr = 1'b1;
    seq_wr_data = 8'hDE;
    step_clk();
    seq_wr = 1'b0;
    run_seq("midwr", 4, {3'b100, 3'b001, 3'b100, 3'b010}, 1'b0, 10, 8'h55);
    run_seq("after", 4, {3'b001, 3'b001, 3'b001, 3'b001}, 1'b0, 0, 8'h00);

    // Abort with clr during the second ON step.
    start = 1'b1;
    step_clk();
    start = 1'b0;
    chk("abort.s0led", 32'(led), 32'h1);
    repeat (7) step_clk();
    chk("abort.s1led", 32'(led), 32'h1);
    clr = 1'b1;
    step_clk();
    clr = 1'b0;
    chk("abort.led", 32'(led), 32'd0);
    chk("abort.btn", 32'(btn_pulse), 32'd0);
    chk("abort.enter", 32'(enter_pulse), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step_clk();
      chk("abort.quiet", 32'({enter_pulse, done, busy}), 32'd0);
    end
    run_seq("postclr", 4, {3'b100, 3'b001, 3'b100, 3'b010}, 1'b0, 0, 8'h00);

    // Start held high: back-to-back runs with one IDLE cycle between.
    seq_wr = 1'b1;
    seq_wr_data = 8'h02;
    step_clk();
    seq_wr = 1'b0;
    run_seq("hold1", 1, {9'b0, 3'b010}, 1'b1, 0, 8'h00);
    run_seq("hold2", 1, {9'b0, 3'b010}, 1'b1, 0, 8'h00);
    start = 1'b0;
    run_seq("hold3", 1, {9'b0, 3'b010}, 1'b0, 0, 8'h00);
    step_clk();
    chk("final.busy", 32'(busy), 32'd0);
    chk("final.led", 32'(led), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 62500000, LED-on time per step in clk cycles (500 ms at 125 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 12500000, dark time after each step in clk cycles (100 ms).
REQ-003 SHALL have parameter RST_CODE, default 8'hDE, reset sequence (steps 2,3,1,3).
REQ-004 clk  input  1  system clock, 125 MHz; the block uses this one clock only.
REQ-005 clr  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  request playback; sampled only in IDLE.
REQ-007 seq_wr  input  1  load seq_wr_data into the code register this cycle.
REQ-008 seq_wr_data  input  8  four 2-bit steps, step0 in [1:0], step3 in [7:6]; value = button index 1..3, 0 = end of sequence.
REQ-009 led  output  3  led[n] lit while button n is being shown (bit 0 = button 1).
REQ-010 btn_pulse  output  3  one-cycle pulse on bit of current step's button, first ON cycle of each step.
REQ-011 enter_pulse  output  1  one-cycle pulse after the final step (emulates the enter button).
REQ-012 busy  output  1  high from first ON/ENTER cycle through ENTER cycle inclusive.
REQ-013 done  output  1  one-cycle pulse in the cycle after enter_pulse.

Function
REQ-014 FSM states SHALL be IDLE, ON, GAP, ENTER, FIN.
REQ-015 IDLE: start=1 SHALL snapshot code register into play register, step index=0, counter=0; next state ON if step0!=0, else ENTER.
REQ-016 ON: led SHALL be one-hot on current step's button, counter increments each cycle; after ON_CYCLES cycles in ON, go to GAP with counter=0.
REQ-017 btn_pulse SHALL be high only in the first cycle of each ON visit, same bit as led.
REQ-018 GAP: led=0; after GAP_CYCLES cycles, step index increments; next state ENTER if new index==4 or its code==0, else ON.
REQ-019 ENTER: exactly one cycle, enter_pulse=1, led=0; next state FIN.
REQ-020 FIN: exactly one cycle, done=1, busy=0; next state IDLE.
REQ-021 Playback duration for k valid steps SHALL be k*(ON_CYCLES+GAP_CYCLES)+1 cycles of busy.
REQ-022 start while not in IDLE SHALL be ignored (no queuing).
REQ-023 seq_wr SHALL be accepted in any state; it updates the code register only, never the in-progress play register; takes effect on the next start.
REQ-024 seq_wr and start in the same IDLE cycle: the snapshot SHALL take the new seq_wr_data.
REQ-025 A 0 step ends the sequence; steps after a 0 SHALL be ignored even if nonzero.
REQ-026 Counter width SHALL be 27 bits; ON_CYCLES and GAP_CYCLES SHALL be >=1 and <2^27.
REQ-027 All outputs SHALL be registered (no combinational path from inputs to outputs).

Reset
REQ-028 clr=1 SHALL force state IDLE, counter 0, step index 0, code and play registers RST_CODE, all outputs 0, on the next clk edge.
REQ-029 clr during playback SHALL abort immediately; no enter_pulse or done is emitted.
REQ-030 clr SHALL take priority over start and seq_wr in the same cycle.

Structure
REQ-031 State encodings, 2-bit step-code width, and RST_CODE default SHALL live in a shared package with the sequence detector's button indices.
REQ-032 One sub-module, step_timer (loadable 27-bit terminal-count counter), SHALL implement ON/GAP timing; all else in seq_player.

Verification (ON_CYCLES=4, GAP_CYCLES=2)
REQ-033 Reset default, pulse start -> led sequence 3'b010,3'b100,3'b001,3'b100 each 4 cycles with 2-cycle gaps; enter_pulse at busy cycle 25; done next cycle.
REQ-034 seq_wr_data=8'h01 then start -> single step led=3'b001 for 4 cycles, gap 2, enter_pulse; busy 7 cycles.
REQ-035 seq_wr_data=8'h00 then start -> enter_pulse in the cycle after start-sampled, no led/btn_pulse activity.
REQ-036 seq_wr 8'h55 mid-playback of 8'hDE -> current run unchanged; next start plays 1,1,1,1.
REQ-037 clr asserted in second ON step -> next cycle all outputs 0, no enter_pulse/done; subsequent start plays RST_CODE.
REQ-038 start held high continuously -> back-to-back runs separated by exactly one IDLE cycle after FIN; start pulses during busy ignored.
